uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first, idle-high line. Recovers bytes from the off-chip `rx` pin and hands them to the sensor-hub core over a one-entry valid/ready holding register. Pairs with the hub's UART transmitter at the same `DIV`. Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, frame width and
// default bit-period divider (50 MHz system clock / 115200 baud).
package uart_pkg;
  localparam int UART_DATA_BITS   = 8;
  localparam int UART_DIV_DEFAULT = 434;
  localparam int UART_CNT_W       = 16;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioner for the asynchronous rx pin.
//   clk, rst : system clock, async active-high reset
//   rx       : raw serial line
//   rx_s     : rx after a 2-flop synchronizer
//   fall     : 1 when the synchronized line just went 1 -> 0
// All flops reset to 1 (idle line level).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic s1, s2, hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      hist <= 1'b1;
    end else begin
      s1   <= rx;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign rx_s = s2;
  // Edge-only start: a line that stays low produces no further edges.
  assign fall = hist & ~s2;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line, with a one-entry
// valid/ready holding register toward the core.
//   DIV       : clk cycles per bit (4..65535)
//   clk, rst  : system clock, async active-high reset
//   rx        : serial input (asynchronous)
//   data_out  : received byte, stable while valid
//   valid     : holding register full
//   ready     : consumer accepts on valid && ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : sticky, byte completed while holding register stayed full
//   ovr_clr   : synchronous clear of overrun (a same-cycle set wins)
//   busy      : receiver not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = UART_DIV_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      overrun,
  input  logic                      ovr_clr,
  output logic                      busy
);
  localparam logic [UART_CNT_W-1:0] HALF_M1 = UART_CNT_W'(DIV / 2 - 1);
  localparam logic [UART_CNT_W-1:0] FULL_M1 = UART_CNT_W'(DIV - 1);
  localparam logic [2:0]            LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rx_s, fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  uart_state_e               state, state_n;
  logic [UART_CNT_W-1:0]     cnt;
  logic [2:0]                bitpos;
  logic [UART_DATA_BITS-1:0] sh;
  logic                      cnt_zero;

  // FSM control strobes
  logic ld_half, ld_full, dec, shift, clr_bitpos, stop_ok, stop_bad;

  assign cnt_zero = (cnt == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (fall) state_n = START;
      // Line back high at mid-start: treat as a glitch.
      START: if (cnt_zero) state_n = rx_s ? IDLE : DATA;
      DATA:  if (cnt_zero && bitpos == LAST_BIT) state_n = STOP;
      STOP:  if (cnt_zero) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    ld_half    = 1'b0;
    ld_full    = 1'b0;
    dec        = 1'b0;
    shift      = 1'b0;
    clr_bitpos = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE:  ld_half = fall;
      START: begin
        if (cnt_zero) begin
          ld_full    = ~rx_s;
          clr_bitpos = ~rx_s;
        end else begin
          dec = 1'b1;
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shift   = 1'b1;
          ld_full = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      STOP: begin
        if (cnt_zero) begin
          stop_ok  = rx_s;
          stop_bad = ~rx_s;
        end else begin
          dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // Bit timing and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      bitpos <= '0;
      sh     <= '0;
    end else begin
      if (ld_half)      cnt <= HALF_M1;
      else if (ld_full) cnt <= FULL_M1;
      else if (dec)     cnt <= cnt - 1'b1;

      if (clr_bitpos)   bitpos <= '0;
      else if (shift)   bitpos <= bitpos + 3'd1;

      if (shift) sh <= {rx_s, sh[UART_DATA_BITS-1:1]};
    end
  end

  // Holding register; a byte may land in the same cycle the old one is taken.
  logic take, accept, lost;
  assign take   = valid & ready;
  assign accept = stop_ok & (~valid | ready);
  assign lost   = stop_ok & valid & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (accept) begin
        data_out <= sh;
        valid    <= 1'b1;
      end else if (take) begin
        valid <= 1'b0;
      end
      if (lost)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=16.
module tb_uart_rx;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst, rx, ready, ovr_clr;
  logic [7:0] data_out;
  logic       valid, frame_err, overrun, busy;

  uart_rx #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling clock edge.
  int         vcount = 0, vhigh = 0, fe_count = 0, r0 = 0, r1 = 0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       v_prev = 1'b0;
  always @(negedge clk) begin
    if (valid && !v_prev) begin
      if (vcount == 0) begin r0 = cyc; d0 = data_out; end
      else begin r1 = cyc; d1 = data_out; end
      vcount++;
    end
    if (valid) vhigh++;
    if (frame_err) fe_count++;
    v_prev = valid;
  end

  task automatic clr_mon();
    vcount = 0; vhigh = 0; fe_count = 0; r0 = 0; r1 = 0;
  endtask

  // Drive the first n bit periods of a frame {stop, byte, start}.
  task automatic drive_bits(input logic [7:0] b, input logic stop, input int n);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      rx = f[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; ready = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", data_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe: got %0b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %0b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int st;
    @(negedge clk);
    clr_mon();
    ready = 1'b0;
    st = cyc;
    drive_bits(8'hA5, 1'b1, 10);
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data: got %0h expected a5", data_out); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", valid); end
    // valid first seen after edge 154, i.e. 155 posedges after drive start
    checks++; if (r0 - st !== 155) begin errors++; $display("FAIL basic_latency: got %0d expected 155", r0 - st); end
    checks++; if (fe_count !== 0) begin errors++; $display("FAIL basic_fe: got %0d expected 0", fe_count); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_consume: got %0b expected 0", valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_hold: got %0h expected a5", data_out); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    clr_mon();
    ready = 1'b1;
    drive_bits(8'h3C, 1'b1, 10);
    drive_bits(8'hC3, 1'b1, 10);
    repeat (4) @(negedge clk);
    checks++; if (vcount !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", vcount); end
    checks++; if (vhigh !== 2) begin errors++; $display("FAIL b2b_width: got %0d expected 2", vhigh); end
    checks++; if (r1 - r0 !== 160) begin errors++; $display("FAIL b2b_spacing: got %0d expected 160", r1 - r0); end
    checks++; if (d0 !== 8'h3C) begin errors++; $display("FAIL b2b_byte0: got %0h expected 3c", d0); end
    checks++; if (d1 !== 8'hC3) begin errors++; $display("FAIL b2b_byte1: got %0h expected c3", d1); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %0b expected 0", overrun); end
  endtask

  task automatic test_frame_err();
    @(negedge clk);
    clr_mon();
    drive_bits(8'h55, 1'b0, 10);
    // line stays low as a break, then releases
    repeat (20 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    checks++; if (fe_count !== 1) begin errors++; $display("FAIL fe_pulse: got %0d expected 1", fe_count); end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL fe_novalid: got %0d expected 0", vcount); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fe_valid: got %0b expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    clr_mon();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (7) @(negedge clk);  // after edge 9: still in START
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %0b expected 1", busy); end
    @(negedge clk);             // after edge 10: start check saw 1
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %0b expected 0", busy); end
    repeat (12 * DIV) @(negedge clk);
    checks++; if (vcount !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", vcount); end
    checks++; if (fe_count !== 0) begin errors++; $display("FAIL glitch_fe: got %0d expected 0", fe_count); end
  endtask

  task automatic test_overrun();
    @(negedge clk);
    clr_mon();
    ready = 1'b0;
    drive_bits(8'h11, 1'b1, 10);
    drive_bits(8'h22, 1'b1, 10);
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL ovr_data: got %0h expected 11", data_out); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %0b expected 1", valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0b expected 1", overrun); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_consume: got %0b expected 0", valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0b expected 1", overrun); end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %0b expected 0", overrun); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clr_mon();
    ready = 1'b0;
    drive_bits(8'h99, 1'b1, 5);  // start + bits 0..3
    rx = 1'b1;                   // bit 4 of 0x99
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", busy); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data: got %0h expected 0", data_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", valid); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    checks++; if (vcount !== 0) begin errors++; $display("FAIL mid_partial: got %0d expected 0", vcount); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got %0b expected 0", busy); end
    drive_bits(8'h5A, 1'b1, 10);
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL mid_next_data: got %0h expected 5a", data_out); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_next_valid: got %0b expected 1", valid); end
    checks++; if (fe_count !== 0) begin errors++; $display("FAIL mid_next_fe: got %0d expected 0", fe_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
